// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Also carries the core-wide default word and address widths.
package mem_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_AW    = 6;

  typedef enum logic {
    PRIO_D,
    PRIO_IF
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between fetch and data access.
// Data wins by default; a starvation counter forces fetch priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             stall_fetch,
  output logic             stall_mem,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  owner_e          rd_own_q, rd_own_d;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        PRIO_D: begin
          d_gnt  = d_req;
          if_gnt = if_req & ~d_req;
        end
        PRIO_IF: begin
          if_gnt = if_req;
          d_gnt  = d_req & ~if_req;
        end
      endcase
    end
  end

  // Starvation count, priority flip and read-owner tag for next cycle.
  always_comb begin
    starve_d = '0;
    state_d  = state_q;
    rd_own_d = OWN_NONE;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == SMAX) ? SMAX : starve_q + CW'(1);
    end
    unique case (state_q)
      PRIO_D:  if (starve_d == SMAX) state_d = PRIO_IF;
      PRIO_IF: if (if_gnt)           state_d = PRIO_D;
    endcase
    if (if_gnt) begin
      rd_own_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      rd_own_d = OWN_D;
    end
  end

  // State, counter and owner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PRIO_D;
      starve_q <= '0;
      rd_own_q <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rd_own_q <= rd_own_d;
    end
  end

  // Memory side driven by whichever port holds the grant.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign mem_en      = if_gnt | d_gnt;
  assign mem_we      = d_gnt & d_we;
  assign stall_fetch = if_req & ~if_gnt;
  assign stall_mem   = d_req & ~d_gnt;

  // A read in flight when reset arrives is dropped.
  assign if_rvalid = (rd_own_q == OWN_IF) & ~reset;
  assign d_rvalid  = (rd_own_q == OWN_D) & ~reset;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one single-port synchronous word memory between the fetch stage (instruction reads) and the memory-access stage (loads/stores) of the 5-stage in-order core. It sits between the pipeline and the unified memory and grants one requester per cycle. Data has priority by default, with a starvation counter that guarantees fetch progress. It returns read data to the owner one cycle later and drives per-port stall signals to the pipeline hazard logic.

## Interface
Parameters:
- WIDTH, 32, data word width
- AW, 6, word-address width (matches the 6-bit data-memory word address)
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets forced priority (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  WIDTH  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered; never for stores)
- d_rdata  out  WIDTH  load data
- stall_fetch  out  1  if_req & ~if_gnt
- stall_mem  out  1  d_req & ~d_gnt
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory word address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, valid the cycle after a read with mem_en=1, mem_we=0

## Operation
- Arbitration is a 2-state FSM: PRIO_D (reset state) and PRIO_IF.
  - PRIO_D: d_req wins over if_req. Lone requests are always granted.
  - PRIO_IF: if_req wins over d_req.
- Starvation counter `starve` is 0..STARVE_MAX and saturates.
  - Increments when if_req & ~if_gnt.
  - Clears when if_gnt=1 or if_req=0.
- PRIO_D → PRIO_IF at the clock edge where `starve` becomes STARVE_MAX.
- PRIO_IF → PRIO_D at the clock edge of the first if_gnt. `starve` clears on that edge.
- Granted port drives the memory:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr/mem_wdata are muxed from the granted port. mem_wdata = 0 when fetch is granted.
  - With no grant: mem_addr = 0, mem_wdata = 0.
- Read owner tag (registered): `rd_own` ∈ {NONE, IF, D}. It is set to IF on if_gnt, D on d_gnt & ~d_we, NONE otherwise.
- Return path:
  - if_rvalid = (rd_own==IF), d_rvalid = (rd_own==D).
  - if_rdata/d_rdata = mem_rdata when the matching rvalid is 1, else 0.
- Back-to-back grants every cycle are legal; throughput is one access per cycle.
- Requesters hold req/addr/data stable until granted. Behaviour on a withdrawn ungranted request: it is simply not served.

## Timing
- Grant latency: 0 cycles (same cycle as req, when the port wins).
- Read latency: rvalid 1 cycle after grant. Stores complete at the grant-cycle edge.
- Reset values: state=PRIO_D, starve=0, rd_own=NONE. Therefore if_rvalid=d_rvalid=0 and both rdata=0. Combinational outputs follow inputs during reset, except that grants are forced to 0 while reset=1 (so mem_en=0 and stall_* = req).
- Reset asserted the cycle after a read grant: that read's rvalid is suppressed.
- Simultaneous requests with starve reaching STARVE_MAX on this edge: this cycle still follows PRIO_D. Priority flips from the next cycle.
- Simultaneous store and fetch: only one is granted. The loser stalls and sees no side effects.
- A load and a store to the same address in consecutive cycles: the memory provides write-then-read ordering. The arbiter adds no bypass.

## Structure
- Shared package holds:
  - arbiter state enum {PRIO_D, PRIO_IF}
  - owner enum {OWN_NONE, OWN_IF, OWN_D}
  - default WIDTH/AW constants shared with the core top level
- Single module. No sub-module needed. The starvation counter is small enough to stay inline.

## Test plan
- Reset held 2 cycles with if_req=d_req=1 → if_gnt=d_gnt=0, mem_en=0, stall_fetch=stall_mem=1. After release, d_gnt=1 first.
- Fetch only: if_req=1, if_addr=5, mem_rdata=0xDEADBEEF next cycle → if_gnt=1 in the same cycle, mem_addr=5, if_rvalid=1 with if_rdata=0xDEADBEEF one cycle later, d_rvalid=0.
- Store then load: d_req, d_we=1, d_addr=3, d_wdata=0x12345678, then a load at addr 3 → mem_we=1 only in the first cycle. d_rvalid=1 with 0x12345678 two cycles after the store grant. No rvalid for the store.
- Starvation with STARVE_MAX=4: both requesting continuously → d_gnt for 4 cycles, stall_fetch=1 for those 4, if_gnt in the 5th cycle, then d_gnt resumes in the 6th.
- Alternating ownership with back-to-back grants: fetch@7, load@9, fetch@8 over 3 cycles → rvalid routed to the correct port each following cycle, with no cross-talk (the other port's rdata=0).
- Reset asserted the cycle after a load grant → d_rvalid stays 0, and state/starve return to PRIO_D/0.
